mealy_101_nonoverlap: RTL and testbench

MEALY_101_NONOVERLAP -- requirements
Module: mealy_101_nonoverlap

---
 rtl/mealy_101_nonoverlap.sv | 126 ++++++++++++
 tb/tb_mealy_101_nonoverlap.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mealy_101_nonoverlap.sv
// ---------------------------------------------------------------------------
// mealy_101_nonoverlap
//
// Purpose:
//   Serial Mealy detector for the bit pattern "101" on din. Detection is
//   non-overlapping: the '1' that completes a match is not reused as the
//   first bit of the next match. An optional saturating counter records
//   how many matches have been seen since reset or the last clear.
//
// Configuration:
//   MEALY101_DET_COUNT_EN  - when defined, the detection counter and its
//                            synchronous clear (cnt_clr) are built. When
//                            undefined, det_count is tied to zero and
//                            cnt_clr is ignored. The FSM and dout behave
//                            the same in both builds.
//
// Parameters:
//   COUNT_W    - width of det_count (default 8)
//
// Ports:
//   clk        - input,  1 bit : clock, all state changes on its rising edge
//   rst        - input,  1 bit : asynchronous active-high reset
//   din        - input,  1 bit : serial data bit
//   en         - input,  1 bit : sample enable, din is consumed only when 1
//   cnt_clr    - input,  1 bit : synchronous clear of det_count
//   dout       - output, 1 bit : Mealy detect flag, high in the cycle whose
//                                din completes "101"
//   state_o    - output, 2 bits: registered FSM state, for debug
//   det_count  - output, COUNT_W bits: number of detections (saturating)
// ---------------------------------------------------------------------------
module mealy_101_nonoverlap #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               en,
    input  logic               cnt_clr,
    output logic               dout,
    output logic [1:0]         state_o,
    output logic [COUNT_W-1:0] det_count
);

    // The fourth encoding is named so the default branch of the next-state
    // logic has something explicit to recover from.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GOT1    = 2'b01,
        GOT10   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t state;
    state_t next_state;
    logic   detect;

    // State register. Reset is asynchronous so the partial match is dropped
    // the moment rst rises, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Mealy output. With en low every legal state holds and
    // no detect is reported. A completed match always returns to IDLE,
    // which is what makes the detector non-overlapping. The illegal
    // encoding recovers to IDLE on the next edge whether or not en is high,
    // and never raises the detect flag.
    always_comb begin
        next_state = state;
        detect     = 1'b0;
        case (state)
            IDLE: begin
                if (en && din) begin
                    next_state = GOT1;
                end
            end
            GOT1: begin
                if (en && !din) begin
                    next_state = GOT10;
                end
            end
            GOT10: begin
                if (en) begin
                    next_state = IDLE;
                    detect     = din;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign dout    = detect;
    assign state_o = state;

`ifdef MEALY101_DET_COUNT_EN
    logic [COUNT_W-1:0] count;

    // Detection counter. Clear wins over a simultaneous detect; once the
    // counter is all ones it stays there instead of wrapping to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (cnt_clr) begin
            count <= '0;
        end else if (detect && (count != {COUNT_W{1'b1}})) begin
            count <= count + COUNT_W'(1);
        end
    end

    assign det_count = count;
`else
    // Counter not built: the output is a constant and the clear input is
    // deliberately left without effect.
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign det_count      = '0;
`endif

endmodule

// File: tb/tb_mealy_101_nonoverlap.sv
// ---------------------------------------------------------------------------
// tb_mealy_101_nonoverlap
//
// Scoreboard bench for mealy_101_nonoverlap. A driver applies directed
// vectors (with hand-computed expected dout and state) on the falling clock
// edge and pushes the expected response into a queue; a monitor samples the
// DUT shortly after each falling edge, pops and compares.
// ---------------------------------------------------------------------------
module tb_mealy_101_nonoverlap;

    localparam int COUNT_W   = 2;
    localparam int COUNT_MAX = (1 << COUNT_W) - 1;

    logic               clk;
    logic               rst;
    logic               din;
    logic               en;
    logic               cnt_clr;
    logic               dout;
    logic [1:0]         state_o;
    logic [COUNT_W-1:0] det_count;

    typedef struct {
        string              tag;
        logic               exp_dout;
        logic [1:0]         exp_state;
        logic [COUNT_W-1:0] exp_count;
    } exp_t;

    exp_t expQueue[$];

    int compared   = 0;
    int mismatched = 0;
    int expCount   = 0;
    bit countEnabled;

    mealy_101_nonoverlap #(
        .COUNT_W (COUNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .en        (en),
        .cnt_clr   (cnt_clr),
        .dout      (dout),
        .state_o   (state_o),
        .det_count (det_count)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs on the falling edge and queue what the DUT
    // must show during that cycle. The expected count is the value held
    // before the coming rising edge; it is then advanced for the next cycle.
    task automatic applyStimulus(input string tag, input logic r, input logic e,
                                 input logic d, input logic c,
                                 input logic expD, input logic [1:0] expS);
        exp_t item;
        @(negedge clk);
        rst     = r;
        en      = e;
        din     = d;
        cnt_clr = c;
        if (r) expCount = 0;
        item.tag       = tag;
        item.exp_dout  = expD;
        item.exp_state = expS;
        item.exp_count = countEnabled ? COUNT_W'(expCount) : '0;
        expQueue.push_back(item);
        if (r)                                    expCount = 0;
        else if (c)                               expCount = 0;
        else if (expD && expCount < COUNT_MAX)    expCount = expCount + 1;
    endtask

    task automatic checkOutput(input exp_t item);
        compared++;
        if (dout !== item.exp_dout) begin
            mismatched++;
            $display("[TB] FAIL %s dout: got %b expected %b", item.tag, dout, item.exp_dout);
        end
        compared++;
        if (state_o !== item.exp_state) begin
            mismatched++;
            $display("[TB] FAIL %s state_o: got %b expected %b", item.tag, state_o, item.exp_state);
        end
        compared++;
        if (det_count !== item.exp_count) begin
            mismatched++;
            $display("[TB] FAIL %s det_count: got %0d expected %0d", item.tag, det_count, item.exp_count);
        end
    endtask

    // Monitor: the DUT presents a fresh response every cycle, sampled two
    // time units after the falling edge once the driver has settled inputs.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (expQueue.size() > 0) begin
                checkOutput(expQueue.pop_front());
            end
        end
    end

    initial begin
`ifdef MEALY101_DET_COUNT_EN
        countEnabled = 1'b1;
`else
        countEnabled = 1'b0;
`endif
        rst     = 1'b1;
        en      = 1'b0;
        din     = 1'b0;
        cnt_clr = 1'b0;

        // Reset held for two cycles
        applyStimulus("rst0", 1, 0, 0, 0, 0, 2'b00);
        applyStimulus("rst1", 1, 0, 0, 0, 0, 2'b00);

        // Stream 1,0,1,1,0,1,0,0,1: detects on bits 3 and 6
        applyStimulus("s1b1", 0, 1, 1, 0, 0, 2'b00);
        applyStimulus("s1b2", 0, 1, 0, 0, 0, 2'b01);
        applyStimulus("s1b3", 0, 1, 1, 0, 1, 2'b10);
        applyStimulus("s1b4", 0, 1, 1, 0, 0, 2'b00);
        applyStimulus("s1b5", 0, 1, 0, 0, 0, 2'b01);
        applyStimulus("s1b6", 0, 1, 1, 0, 1, 2'b10);
        applyStimulus("s1b7", 0, 1, 0, 0, 0, 2'b00);
        applyStimulus("s1b8", 0, 1, 0, 0, 0, 2'b00);
        applyStimulus("s1b9", 0, 1, 1, 0, 0, 2'b00);

        // Continue 1,0 then 0 then 1,0,1: only the final 101 detects
        applyStimulus("s2b1", 0, 1, 1, 0, 0, 2'b01);
        applyStimulus("s2b2", 0, 1, 0, 0, 0, 2'b01);
        applyStimulus("s2b3", 0, 1, 0, 0, 0, 2'b10);
        applyStimulus("s2b4", 0, 1, 1, 0, 0, 2'b00);
        applyStimulus("s2b5", 0, 1, 0, 0, 0, 2'b01);
        applyStimulus("s2b6", 0, 1, 1, 0, 1, 2'b10);
        applyStimulus("s2hold", 0, 0, 0, 0, 0, 2'b00);

        // 1,0,1,0,1 non-overlapping: one detect on bit 3, ends in GOT1
        applyStimulus("s3b1", 0, 1, 1, 0, 0, 2'b00);
        applyStimulus("s3b2", 0, 1, 0, 0, 0, 2'b01);
        applyStimulus("s3b3", 0, 1, 1, 0, 1, 2'b10);
        applyStimulus("s3b4", 0, 1, 0, 0, 0, 2'b00);
        applyStimulus("s3b5", 0, 1, 1, 0, 0, 2'b00);
        applyStimulus("s3end", 0, 0, 0, 0, 0, 2'b01);

        // Clear with en low: count drops, state stays GOT1
        applyStimulus("clr", 0, 0, 0, 1, 0, 2'b01);

        // 1,0 then en=0 with din=1 for 3 cycles, then re-enable with 1
        applyStimulus("enb1", 0, 1, 1, 0, 0, 2'b01);
        applyStimulus("enb2", 0, 1, 0, 0, 0, 2'b01);
        applyStimulus("enoff0", 0, 0, 1, 0, 0, 2'b10);
        applyStimulus("enoff1", 0, 0, 1, 0, 0, 2'b10);
        applyStimulus("enoff2", 0, 0, 1, 0, 0, 2'b10);
        applyStimulus("enon", 0, 1, 1, 0, 1, 2'b10);

        // 1,0, reset pulse mid-pattern, then 1: no detect, ends in GOT1
        applyStimulus("rpb1", 0, 1, 1, 0, 0, 2'b00);
        applyStimulus("rpb2", 0, 1, 0, 0, 0, 2'b01);
        applyStimulus("rppulse", 1, 1, 1, 0, 0, 2'b00);
        applyStimulus("rpb3", 0, 1, 1, 0, 0, 2'b00);
        applyStimulus("rpend", 0, 0, 0, 0, 0, 2'b01);
        applyStimulus("rpidle", 0, 1, 1, 0, 0, 2'b01);
        applyStimulus("rpidle2", 0, 1, 1, 0, 0, 2'b01);
        applyStimulus("rpidle3", 0, 1, 0, 0, 0, 2'b01);
        applyStimulus("rpidle4", 0, 1, 0, 0, 0, 2'b10);

        // Six detections: counter saturates at 3
        for (int i = 0; i < 6; i++) begin
            applyStimulus("sat1", 0, 1, 1, 0, 0, 2'b00);
            applyStimulus("sat0", 0, 1, 0, 0, 0, 2'b01);
            applyStimulus("satd", 0, 1, 1, 0, 1, 2'b10);
        end
        applyStimulus("satchk", 0, 0, 0, 0, 0, 2'b00);

        // Clear together with a detect: clear wins
        applyStimulus("cd1", 0, 1, 1, 0, 0, 2'b00);
        applyStimulus("cd0", 0, 1, 0, 0, 0, 2'b01);
        applyStimulus("cdd", 0, 1, 1, 1, 1, 2'b10);
        applyStimulus("cdchk", 0, 0, 0, 0, 0, 2'b00);

        @(negedge clk);
        en      = 1'b0;
        din     = 1'b0;
        cnt_clr = 1'b0;
        for (int w = 0; w < 20 && expQueue.size() > 0; w++) begin
            @(negedge clk);
        end
        #3;
        compared++;
        if (expQueue.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQueue.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
